// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline constants and the source/destination hazard test
package mips_pkg;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;
  localparam logic [1:0] T_0 = 2'd0;
  localparam logic [1:0] T_1 = 2'd1;
  localparam logic [1:0] T_2 = 2'd2;
  localparam logic [1:0] T_NEVER = 2'd3;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic logic src_hit(logic [4:0] src, logic [1:0] tuse, logic [4:0] a3, logic [1:0] tnew);
    return (src != REG_ZERO) && (src == a3) && (tuse < tnew);
  endfunction
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline-to-controller hazard and stall signals
interface hazard_stall_ctrl_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_tuse_rs;
  logic [1:0] D_tuse_rt;
  logic D_is_md;
  logic [4:0] E_A3;
  logic [1:0] E_tnew;
  logic [4:0] M_A3;
  logic [1:0] M_tnew;
  logic E_md_start;
  logic E_md_is_div;
  logic pc_we;
  logic fd_we;
  logic de_clr;
  logic md_busy;
  logic md_done;
  logic [31:0] stall_cnt;
  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md, E_A3, E_tnew, M_A3, M_tnew, E_md_start, E_md_is_div,
    input pc_we, fd_we, de_clr, md_busy, md_done, stall_cnt
  );
  modport slave (
    input D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md, E_A3, E_tnew, M_A3, M_tnew, E_md_start, E_md_is_div,
    output pc_we, fd_we, de_clr, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/md_busy_timer.sv
// md_busy_timer: multiply/divide busy countdown with last-cycle done pulse
module md_busy_timer import mips_pkg::*; #(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic is_div,
  output logic busy,
  output logic done
);
  logic [3:0] md_cnt_q, md_cnt_d;
  always_comb begin
    busy = md_cnt_q != 4'd0;
    done = md_cnt_q == 4'd1;
    md_cnt_d = (start && !busy) ? (is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) : busy ? md_cnt_q - 4'd1 : md_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) md_cnt_q <= 4'd0;
    else md_cnt_q <= md_cnt_d;
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stalls D on data and HI/LO hazards and counts stall cycles
module hazard_stall_ctrl import mips_pkg::*; #(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  hazard_stall_ctrl_if.slave b
);
  logic stall_rs, stall_rt, stall_md, stall;
  logic md_busy, md_done;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .start(b.E_md_start),
    .is_div(b.E_md_is_div),
    .busy(md_busy),
    .done(md_done)
  );
  always_comb begin
    stall_rs = src_hit(b.D_rs, b.D_tuse_rs, b.E_A3, b.E_tnew) || src_hit(b.D_rs, b.D_tuse_rs, b.M_A3, b.M_tnew);
    stall_rt = src_hit(b.D_rt, b.D_tuse_rt, b.E_A3, b.E_tnew) || src_hit(b.D_rt, b.D_tuse_rt, b.M_A3, b.M_tnew);
    stall_md = b.D_is_md && (md_busy || b.E_md_start);
    stall = stall_rs || stall_rt || stall_md;
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    b.pc_we = !stall;
    b.fd_we = !stall;
    b.de_clr = stall;
    b.md_busy = md_busy;
    b.md_done = md_done;
    b.stall_cnt = stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= 32'd0;
    else stall_cnt_q <= stall_cnt_d;
  end
endmodule
